aes192_key_sched_ctrl: RTL



---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_subword.sv | 14 +
 rtl/aes192_key_sched_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and byte-level helpers
// (S-box lookup, xtime) used by the key-schedule controllers.
package aes_pkg;

    localparam int AES192_NK     = 6;
    localparam int AES192_NR     = 12;
    localparam int AES_NB        = 4;
    localparam int AES192_NWORDS = 52;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_SUBW,
        KS_READY
    } ks_state_e;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    always_comb begin
        word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                    sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

endmodule

// File: rtl/aes192_key_sched_ctrl.sv
// Iterative AES-192 key schedule: one expanded word per cycle via a shared SubWord,
// round keys served through a registered read port. AES_KS_SBOX_REG_EN registers SubWord.
module aes192_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NK         = AES192_NK,
    parameter int NR         = AES192_NR,
    parameter int CLR_ON_RST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [191:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         rk_vld
);

    localparam int         NWORDS  = AES_NB * (NR + 1);
    localparam logic [5:0] LAST_W  = 6'(NWORDS - 1);
    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [2:0] PH_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_W    = 4'(NR);

    ks_state_e   state;
    ks_state_e   state_next;
    logic [31:0] w [NWORDS];
    logic [5:0]  wcnt;
    logic [2:0]  phase;
    logic [7:0]  rcon;

    logic        accept;
    logic        wr_en;
    logic [5:0]  prev_idx;
    logic [5:0]  back_idx;
    logic [31:0] prev_w;
    logic [31:0] back_w;
    logic [31:0] rot_w;
    logic [31:0] sub_w;
    logic [31:0] t_word;

    logic        rd_in_range;
    logic        rd_ok;
    logic [5:0]  rd_base;

`ifdef AES_KS_SBOX_REG_EN
    logic [31:0] sub_q;
    logic        sub_load;
`endif

    assign accept = key_valid && key_ready;

    always_comb begin
        busy = (state == KS_EXPAND) || (state == KS_SUBW);
    end

    always_comb begin
        prev_idx = busy ? (wcnt - 6'd1) : '0;
        back_idx = busy ? (wcnt - NK_W) : '0;
        prev_w   = w[prev_idx];
        back_w   = w[back_idx];
        rot_w    = {prev_w[23:0], prev_w[31:24]};
    end

    aes_subword u_subword (
        .word_in  (rot_w),
        .word_out (sub_w)
    );

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        t_word     = prev_w;
`ifdef AES_KS_SBOX_REG_EN
        sub_load   = 1'b0;
`endif
        case (state)
            KS_IDLE, KS_READY: begin
                if (accept) state_next = KS_EXPAND;
            end
            KS_EXPAND: begin
`ifdef AES_KS_SBOX_REG_EN
                // Phase-0 words spend this cycle loading the SubWord register.
                if (phase == '0) begin
                    sub_load   = 1'b1;
                    state_next = KS_SUBW;
                end else begin
                    wr_en = 1'b1;
                end
`else
                wr_en = 1'b1;
                if (phase == '0) t_word = sub_w ^ {rcon, 24'h0};
`endif
            end
`ifdef AES_KS_SBOX_REG_EN
            KS_SUBW: begin
                wr_en      = 1'b1;
                t_word     = sub_q ^ {rcon, 24'h0};
                state_next = KS_EXPAND;
            end
`endif
            default: state_next = KS_IDLE;
        endcase
        if (wr_en && (wcnt == LAST_W)) state_next = KS_READY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= KS_IDLE;
            wcnt      <= '0;
            phase     <= '0;
            rcon      <= 8'h01;
            key_ready <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            key_ready <= (state_next == KS_IDLE) || (state_next == KS_READY);
            done      <= wr_en && (wcnt == LAST_W);
            if (accept) begin
                wcnt  <= NK_W;
                phase <= '0;
                rcon  <= 8'h01;
            end else if (wr_en) begin
                wcnt  <= wcnt + 6'd1;
                phase <= (phase == PH_LAST) ? '0 : phase + 3'd1;
                if (phase == '0) rcon <= xtime(rcon);
            end
        end
    end

`ifdef AES_KS_SBOX_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= '0;
        end else if (sub_load) begin
            sub_q <= sub_w;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLR_ON_RST != 0) begin
                for (int unsigned k = 0; k < NWORDS; k++) w[k] <= '0;
            end
        end else if (accept) begin
            for (int unsigned k = 0; k < NK; k++) begin
                w[k] <= key_in[(NK - 1 - int'(k)) * 32 +: 32];
            end
        end else if (wr_en) begin
            w[wcnt] <= back_w ^ t_word;
        end
    end

    // Validity and data use pre-edge wcnt/storage, so a read racing a key load sees the old schedule.
    always_comb begin
        rd_in_range = (rk_idx <= NR_W);
        rd_ok       = rd_in_range && ({rk_idx, 2'b11} < wcnt);
        rd_base     = rd_in_range ? {rk_idx, 2'b00} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_vld  <= 1'b0;
            rk_data <= '0;
        end else if (rk_rd_en) begin
            rk_vld  <= rd_ok;
            rk_data <= rd_ok ? {w[rd_base], w[rd_base + 6'd1],
                                w[rd_base + 6'd2], w[rd_base + 6'd3]} : '0;
        end else begin
            rk_vld <= 1'b0;
        end
    end

endmodule
